// File: rtl/prefetch_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_pkg
// Shared types and constants for the instruction prefetch unit.
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   DEPTH_DEFAULT : default number of prefetch FIFO entries
//   PC_INCR       : sequential fetch stride in bytes
//   align_word()  : clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package prefetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam logic [31:0] PC_INCR       = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// Synchronous FIFO of fetch_entry_t holding fetched words until decode takes
// them. Flush has priority over push/pop. Pop on empty is ignored.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush_i       : drop all entries this cycle
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : remove the head entry
//   count_o       : number of valid entries (0..DEPTH)
//   head_o        : head entry (meaningful only when !empty_o)
//   empty_o       : no valid entries
// -----------------------------------------------------------------------------
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o,
  output logic          empty_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push_i && (!full || do_pop);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries
  // are valid, and the consumer gates head_o with !empty_o.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
// Instruction fetch front end: issues sequential word reads to the
// instruction ROM over a naive_bus-style read port, buffers returned words
// with their PCs, and hands them to decode on a valid/ready handshake.
// A redirect flushes buffered and in-flight words and restarts fetch.
//
// Build option: define FETCH_ALIGN_CHECK_EN to pulse misalign_err_o when a
// redirect target is not word aligned (otherwise misalign_err_o is tied 0).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_req_o/rd_gnt_i   : read request / grant (data follows one cycle later)
//   rd_addr_o           : read word address (= fetch PC)
//   rd_data_i           : read data, valid the cycle after a granted request
//   wr_req_o/wr_addr_o/wr_data_o : unused write channel, tied 0
//   redirect_valid_i    : load redirect_pc_i as the new fetch PC
//   redirect_pc_i       : redirect target (low two bits are cleared)
//   instr_valid_o       : head instruction available
//   instr_o, instr_pc_o : head instruction word and its PC
//   instr_ready_i       : decode accepts the head
//   misalign_err_o      : one-cycle pulse on a misaligned redirect
// -----------------------------------------------------------------------------
module instr_prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_req_o,
  input  logic        rd_gnt_i,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        wr_req_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_err_o
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          push, pop, rd_fire;
  logic [CW:0]   occupancy;

  // Buffered plus in-flight words must leave room for one more; a pop in the
  // same cycle is deliberately not credited to keep this path short.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  // rst_n gates the request so the bus sees no read while reset is held.
  assign rd_req_o  = rst_n && !redirect_valid_i && (occupancy < DEPTH_LIM);
  assign rd_addr_o = fetch_pc_q;
  assign rd_fire   = rd_req_o && rd_gnt_i;

  assign wr_req_o  = 1'b0;
  assign wr_addr_o = '0;
  assign wr_data_o = '0;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push       = inflight_q && !redirect_valid_i;
  assign push_entry = '{pc: inflight_pc_q, instr: rd_data_i};

  assign instr_valid_o = !fifo_empty && !redirect_valid_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = fifo_empty ? 32'h0 : fifo_head.instr;
  assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_head.pc;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid_i) begin
      fetch_pc_d = align_word(redirect_pc_i);
      inflight_d = 1'b0;
    end else begin
      inflight_d = rd_fire;
      if (rd_fire) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_INCR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_err_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
  assign misalign_err_o = 1'b0;
`endif

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction fetch front end for the HDRVSoC core. Acts as a naive_bus master toward the instruction ROM (e.g. instr_rom_svga), issuing sequential word reads from a fetch PC. It buffers returned words with their PCs in a small FIFO and presents them to the decode stage on a valid/ready handshake. Decode or execute can redirect it (jump/branch), which flushes all buffered and in-flight words.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000: fetch PC after reset
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus  naive_bus.master  —  rd_req/rd_gnt/rd_addr/rd_data used; wr_req tied 0, wr_addr/wr_data tied 0
- redirect_valid  in  1  load new fetch PC this cycle
- redirect_pc  in  32  target PC
- instr_valid  out  1  FIFO head valid
- instr  out  32  FIFO head instruction word
- instr_pc  out  32  PC of FIFO head
- instr_ready  in  1  decode accepts head
- misalign_err  out  1  one-cycle pulse on misaligned redirect (see Configuration)

## Operation
- Registers: fetch_pc, inflight (1 bit), inflight_pc, FIFO of {pc, instr}, count.
- Slave read contract: data for a granted read appears on rd_data exactly one cycle after rd_req&rd_gnt; rd_data is 0 otherwise.
- Issue: rd_req = !redirect_valid && (count + inflight + 1 ≤ DEPTH); rd_addr = fetch_pc. Pop in the same cycle is not credited.
- On rd_req&rd_gnt: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^32, wraps to 0). No gnt: rd_req and rd_addr stay stable next cycle; inflight←0.
- Response: if inflight and !redirect_valid, push {inflight_pc, rd_data}; data pushed as-is, including 0 from out-of-range ROM addresses.
- Pop: instr_valid && instr_ready && !redirect_valid.
- Simultaneous push and pop: count unchanged.
- Redirect (priority over everything): FIFO flushed (count←0), inflight response that cycle discarded, inflight←0, fetch_pc←{redirect_pc[31:2],2'b00}, no rd_req that cycle; instr_valid forced 0 that cycle.
- Overflow impossible by issue rule. Pop on empty is ignored.

## Timing
- Reset values: rd_req 0, rd_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, misalign_err 0, fetch_pc RESET_PC, count 0, inflight 0.
- First rd_req in the first cycle after rst_n deasserts.
- Latency: rd_req&gnt at cycle N → data at N+1 → instr_valid at N+2.
- Sustained throughput: 1 instr/cycle with gnt=1 and instr_ready=1.
- Redirect at cycle R → rd_req with the new address at R+1 → first new instr_valid at R+3.
- Reset asserted mid-operation: all state clears immediately (async). Any pending response is lost.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_valid with redirect_pc[1:0]≠0 pulses misalign_err for exactly that cycle. The redirect still takes effect with the low bits cleared.
- Undefined: low bits silently cleared; misalign_err tied 0.

## Structure
- Package prefetch_pkg: fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}, DEPTH default, PC increment constant 4.
- Sub-module prefetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head output. The top holds PC/issue/inflight logic.

## Test plan
- Reset with RESET_PC=0, instr_rom_svga as slave, instr_ready=1 → outputs 0x000062b3@0x0, 0x000302b7@0x4, 0x06806313@0x8 on consecutive cycles, first valid 2 cycles after first rd_req.
- instr_ready=0 for 20 cycles → exactly DEPTH=4 reads issued, then rd_req stays 0. Release → 4 buffered words then resumed sequence, no loss or duplicate.
- Redirect to 0x130 while a read is in flight → stale word dropped; next delivered 0xed1ff06f@0x130, then 0x00000000@0x134 (out-of-range read).
- Slave stub withholds rd_gnt 3 cycles → rd_req/rd_addr held constant; PC advances only on the granted cycle.
- Redirect to 0x12e: with FETCH_ALIGN_CHECK_EN, misalign_err 1 cycle and fetch at 0x12c (0x00c003b7 next). Without the macro, misalign_err stays 0.
- rst_n pulsed while FIFO holds 3 entries → instr_valid 0 immediately; refetch from RESET_PC.
